// File: rtl/i2s_rx_fifo.sv
// -----------------------------------------------------------------------------
// i2s_rx_fifo
//
// Serial-audio receiver with a show-ahead output FIFO. Words arrive MSB first
// on sd, framed by ws. Each word is tagged with its channel (0 = left,
// 1 = right), truncated or zero-padded to WIDTH bits, and queued for a
// valid/ready consumer. Everything runs on posedge sck.
//
// Parameters
//   WIDTH      : stored sample width in bits (2..32)
//   FIFO_DEPTH : FIFO entries, power of two (2..16)
//   MODE       : 0 = I2S (MSB one sck after the ws edge)
//                1 = left-justified (MSB in the same sck as the ws edge)
//
// Optional feature
//   I2S_RX_PARITY_EN : when defined, each entry also stores the XOR of its
//                      WIDTH data bits, and the out_parity port shows the
//                      parity of the head entry.
//
// Ports
//   sck        in  : bit clock; all logic on posedge
//   reset      in  : synchronous, active-high reset
//   ws         in  : word select (0 = left, 1 = right)
//   sd         in  : serial data, MSB first
//   out_ready  in  : consumer accepts the head entry
//   out_valid  out : FIFO non-empty
//   out_data   out : head sample (don't-care while out_valid = 0)
//   out_chan   out : head channel (don't-care while out_valid = 0)
//   level      out : current occupancy
//   full       out : level == FIFO_DEPTH
//   overflow   out : sticky flag, a completed word was dropped; cleared by reset
//   out_parity out : head parity, 0 while empty (I2S_RX_PARITY_EN only)
// -----------------------------------------------------------------------------
module i2s_rx_fifo #(
  parameter int WIDTH      = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int MODE       = 0
) (
  input  logic                              sck,
  input  logic                              reset,
  input  logic                              ws,
  input  logic                              sd,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [WIDTH-1:0]                  out_data,
  output logic                              out_chan,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              full,
  output logic                              overflow
`ifdef I2S_RX_PARITY_EN
  ,
  output logic                              out_parity
`endif
);

  localparam int CW = $clog2(WIDTH + 1);       // bit counter, holds 0..WIDTH
  localparam int PW = $clog2(FIFO_DEPTH);      // FIFO pointer width
  localparam int LW = $clog2(FIFO_DEPTH + 1);  // occupancy width, holds 0..FIFO_DEPTH

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("i2s_rx_fifo: WIDTH must be in 2..32");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("i2s_rx_fifo: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("i2s_rx_fifo: MODE must be 0 or 1");
  end

  // One FIFO entry: channel tag, sample and (optionally) its parity.
  typedef struct packed {
    logic             chan;
    logic [WIDTH-1:0] data;
`ifdef I2S_RX_PARITY_EN
    logic             parity;
`endif
  } entry_t;

  // ---------------------------------------------------------------------------
  // ws edge detection
  // ---------------------------------------------------------------------------
  logic wsd;       // ws delayed by one sck
  logic wsd_reg;   // ws delayed by two sck
  logic p;         // ws edge: a new word starts this cycle
  logic ch;        // channel of the word that starts on p

  // In I2S framing the MSB lags ws by one sck, so the edge is taken one stage
  // later than in left-justified framing, where MSB and ws change together.
  always_comb begin
    if (MODE == 0) begin
      p  = wsd ^ wsd_reg;
      ch = wsd;
    end else begin
      p  = ws ^ wsd;
      ch = ws;
    end
  end

  // ---------------------------------------------------------------------------
  // Deserialiser
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             started;   // at least one ws edge seen since reset
  logic             cur_chan;  // channel of the word being assembled

  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    shift_nxt = shift;
    cnt_nxt   = cnt;
    if (p) begin
      // New word: MSB lands at the top, the rest starts as zero so a short
      // word ends up zero-padded in its LSBs.
      shift_nxt          = '0;
      shift_nxt[WIDTH-1] = sd;
      cnt_nxt            = CW'(1);
    end else if (started && cnt < CW'(WIDTH)) begin
      // Bit number cnt (counting from the MSB) goes to position WIDTH-1-cnt.
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt == CW'(WIDTH - 1 - i)) shift_nxt[i] = sd;
      end
      cnt_nxt = cnt + CW'(1);
    end
    // Once cnt reaches WIDTH the remaining bits of a long word are ignored.
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  entry_t        mem [FIFO_DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_req;  // a completed word is ready to be stored
  logic          push_ok;   // ... and there is room for it
  logic          drop;      // ... but the FIFO is full and nothing leaves
  logic          pop;

  // The edge that starts a word also terminates the previous one; the very
  // first edge after reset has no previous word behind it.
  assign push_req = p & started;
  assign pop      = out_valid & out_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    wr_entry      = '0;
    wr_entry.chan = cur_chan;
    wr_entry.data = shift;
`ifdef I2S_RX_PARITY_EN
    wr_entry.parity = ^shift;
`endif
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others (wsd/wsd_reg
  // form a real two-stage delay line rather than collapsing into one).
  always_ff @(posedge sck) begin
    if (reset) begin
      wsd      <= 1'b0;
      wsd_reg  <= 1'b0;
      shift    <= '0;
      cnt      <= '0;
      started  <= 1'b0;
      cur_chan <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wsd     <= ws;
      wsd_reg <= wsd;
      shift   <= shift_nxt;
      cnt     <= cnt_nxt;
      if (p) begin
        cur_chan <= ch;
        started  <= 1'b1;
      end

      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);

      // level is kept separately from the pointers so that full and empty
      // remain distinguishable when wr_ptr == rd_ptr.
      unique case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; out_valid (driven by level) is what
  // qualifies its contents, and leaving it unreset lets it map onto plain
  // RAM/flops without a reset tree.
  always_ff @(posedge sck) begin
    if (!reset && push_ok) mem[wr_ptr] <= wr_entry;
  end

  // ---------------------------------------------------------------------------
  // Show-ahead read port
  // ---------------------------------------------------------------------------
  assign head      = mem[rd_ptr];
  assign out_valid = (level != '0);
  assign full      = (level == LW'(FIFO_DEPTH));
  assign out_data  = head.data;
  assign out_chan  = head.chan;
`ifdef I2S_RX_PARITY_EN
  // Gated so the port reads 0 out of reset and whenever the FIFO is empty.
  assign out_parity = out_valid & head.parity;
`endif

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx_fifo
//
// Directed bench for i2s_rx_fifo. dut0 runs I2S framing (MODE=0), dut1 runs
// left-justified framing (MODE=1); both use WIDTH=24, FIFO_DEPTH=4.
// Stimulus pushes each expected {chan, data} entry into a queue; a monitor per
// DUT pops and compares whenever a word is handed over (out_valid & out_ready).
// Inputs change 1 ns after posedge; monitors sample on negedge, direct checks
// are taken 1 ns after posedge.
// -----------------------------------------------------------------------------
module tb_i2s_rx_fifo;

  localparam int W  = 24;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);

  logic          sck = 1'b0;
  logic          reset;

  logic          ws, sd, out_ready;
  logic          out_valid, out_chan, full, overflow;
  logic [W-1:0]  out_data;
  logic [LW-1:0] level;

  logic          ws1, sd1, out_ready1;
  logic          out_valid1, out_chan1, full1, overflow1;
  logic [W-1:0]  out_data1;
  logic [LW-1:0] level1;

`ifdef I2S_RX_PARITY_EN
  logic          out_parity, out_parity1;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [W:0]    sb0[$];
  logic [W:0]    sb1[$];
  logic [W:0]    exp0, exp1;
  logic          carry_bit;   // I2S: LSB of a full-slot word falls in the next slot

  always #5 sck = ~sck;

  i2s_rx_fifo #(.WIDTH(W), .FIFO_DEPTH(D), .MODE(0)) dut0 (
    .sck       (sck),
    .reset     (reset),
    .ws        (ws),
    .sd        (sd),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .level     (level),
    .full      (full),
    .overflow  (overflow)
`ifdef I2S_RX_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  i2s_rx_fifo #(.WIDTH(W), .FIFO_DEPTH(D), .MODE(1)) dut1 (
    .sck       (sck),
    .reset     (reset),
    .ws        (ws1),
    .sd        (sd1),
    .out_ready (out_ready1),
    .out_valid (out_valid1),
    .out_data  (out_data1),
    .out_chan  (out_chan1),
    .level     (level1),
    .full      (full1),
    .overflow  (overflow1)
`ifdef I2S_RX_PARITY_EN
    ,
    .out_parity(out_parity1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  // Monitors: compare every handed-over word against the scoreboard head.
  always @(negedge sck) begin
    if (!reset && out_valid && out_ready) begin
      if (sb0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m0_word: got %h, expected no word (t=%0t)", {out_chan, out_data}, $time);
      end else begin
        exp0 = sb0.pop_front();
        check("m0_word", 32'({out_chan, out_data}), 32'(exp0));
`ifdef I2S_RX_PARITY_EN
        check("m0_parity", 32'(out_parity), 32'(^exp0[W-1:0]));
`endif
      end
    end
  end

  always @(negedge sck) begin
    if (!reset && out_valid1 && out_ready1) begin
      if (sb1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m1_word: got %h, expected no word (t=%0t)", {out_chan1, out_data1}, $time);
      end else begin
        exp1 = sb1.pop_front();
        check("m1_word", 32'({out_chan1, out_data1}), 32'(exp1));
`ifdef I2S_RX_PARITY_EN
        check("m1_parity", 32'(out_parity1), 32'(^exp1[W-1:0]));
`endif
      end
    end
  end

  // One I2S slot on dut0: ws changes in tick 0, MSB follows in tick 1.
  // rdy: 0 = out_ready low, 1 = high, 2 = high only for the push edge.
  // lv_before/lv_after (>=0): expected level just before / after the push edge.
  task automatic send_slot(input logic chan, input logic [31:0] data, input int nbits,
                           input int slen, input int rdy, input int lv_before, input int lv_after);
    for (int j = 0; j < slen; j++) begin
      ws = chan;
      if (j == 0)              sd = carry_bit;
      else if (j - 1 < nbits)  sd = 1'(data >> (nbits - j));
      else                     sd = 1'b0;
      case (rdy)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = (j == 1);
      endcase
      tick();
      if (lv_before >= 0 && j == 0) begin
        check("level_before_push", 32'(level), 32'(lv_before));
        check("valid_before_push", 32'(out_valid), 32'(lv_before > 0));
      end
      if (lv_before >= 0 && j == 1) begin
        check("level_after_push", 32'(level), 32'(lv_after));
        check("valid_after_push", 32'(out_valid), 32'(lv_after > 0));
      end
    end
    carry_bit = (nbits == slen) ? data[0] : 1'b0;
    if (rdy == 2) out_ready = 1'b0;
  endtask

  // One left-justified slot on dut1: MSB in the same tick as the ws change.
  task automatic send_slot1(input logic chan, input logic [31:0] data, input int nbits,
                            input int slen);
    for (int j = 0; j < slen; j++) begin
      ws1 = chan;
      sd1 = (j < nbits) ? 1'(data >> (nbits - 1 - j)) : 1'b0;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; ws = 1'b0; sd = 1'b0; out_ready = 1'b0;
    ws1 = 1'b0; sd1 = 1'b0; out_ready1 = 1'b1; carry_bit = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_full", 32'(full), 0);
    check("rst_overflow", 32'(overflow), 0);

    // Start a right word, then reset mid-word; the partial word must vanish.
    reset = 1'b0;
    for (int j = 0; j < 10; j++) begin
      ws = 1'b1;
      sd = j[0];
      tick();
    end
    reset = 1'b1;
    tick();
    tick();
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_level", 32'(level), 0);
    check("midrst_full", 32'(full), 0);
    check("midrst_overflow", 32'(overflow), 0);
    reset = 1'b0;

    // ws is still high while wsd restarts at 0: that first edge pushes nothing.
    send_slot(1'b1, 32'h0F0F0F, 24, 32, 0, -1, -1);
    check("first_edge_no_push", 32'(level), 0);

    // Stereo frame with out_ready low; valid rises one cycle after the edge.
    sb0.push_back({1'b1, 24'h0F0F0F});
    send_slot(1'b0, 32'hA5A5A5, 24, 32, 0, 0, 1);
    sb0.push_back({1'b0, 24'hA5A5A5});
    send_slot(1'b1, 32'h123456, 24, 32, 0, 1, 2);
    sb0.push_back({1'b1, 24'h123456});
    // 16-bit word in a 16-sck slot: zero-padded.
    send_slot(1'b0, 32'h0000BEEF, 16, 16, 0, 2, 3);
    sb0.push_back({1'b0, 24'hBEEF00});
    // 32-bit word: truncated to the top 24 bits.
    send_slot(1'b1, 32'hDEADBEEF, 32, 32, 0, 3, 4);
    check("full_at_4", 32'(full), 1);
    check("no_ovf_at_4", 32'(overflow), 0);
    sb0.push_back({1'b1, 24'hDEADBE});

    // Full, but a pop coincides with the push edge: accepted, level stays 4.
    send_slot(1'b0, 32'h777777, 24, 32, 2, 4, 4);
    check("push_pop_full_ovf", 32'(overflow), 0);
    check("push_pop_full_full", 32'(full), 1);

    // Full with no pop: 0x777777 is dropped and overflow sticks.
    send_slot(1'b1, 32'h333333, 24, 32, 0, 4, 4);
    check("drop_overflow", 32'(overflow), 1);
    check("drop_full", 32'(full), 1);
    check("drop_level", 32'(level), 4);

    // Drain: the four held words must come out in order.
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb0.size() != 0; k++) begin
      ws = 1'b1;
      sd = 1'b0;
      tick();
    end
    check("drain_sb_empty", 32'(sb0.size()), 0);
    check("drain_level", 32'(level), 0);
    check("drain_valid", 32'(out_valid), 0);
    // Pop request while empty is ignored.
    tick();
    tick();
    check("empty_pop_level", 32'(level), 0);
    check("empty_pop_full", 32'(full), 0);
    check("ovf_sticky", 32'(overflow), 1);

    // Continuous streaming with out_ready high.
    sb0.push_back({1'b1, 24'h333333});
    send_slot(1'b0, 32'h5A5A5A, 24, 32, 1, 0, 1);
    sb0.push_back({1'b0, 24'h5A5A5A});
    send_slot(1'b1, 32'h000000, 24, 32, 1, -1, -1);
    for (int k = 0; k < 10 && sb0.size() != 0; k++) tick();
    check("stream_sb_empty", 32'(sb0.size()), 0);

    // Left-justified framing on dut1.
    send_slot1(1'b1, 32'h800001, 24, 32);
    sb1.push_back({1'b1, 24'h800001});
    send_slot1(1'b0, 32'h800003, 24, 32);
    sb1.push_back({1'b0, 24'h800003});
    send_slot1(1'b1, 32'h000000, 24, 32);
    for (int k = 0; k < 10 && sb1.size() != 0; k++) tick();
    check("m1_sb_empty", 32'(sb1.size()), 0);
    check("m1_overflow", 32'(overflow1), 0);
    check("m1_level", 32'(level1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
